// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator.
// One bit position per clock, early exit on first difference.
module serial_magnitude_comparator #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  output logic                     busy,
  output logic                     done,
  output logic                     lesser,
  output logic                     equal,
  output logic                     greater,
  output logic [$clog2(N+1)-1:0]   cmp_cycles
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [IW-1:0]  idx;
  logic           abit;
  logic           bbit;
  logic           diff;
  logic           last;
  logic           accept;

  assign abit   = a_reg[idx];
  assign bbit   = b_reg[idx];
  assign diff   = abit ^ bbit;
  assign last   = (idx == '0);
  assign accept = (state == IDLE) && start;

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = COMPARE;
      COMPARE: if (diff || last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx        <= '0;
      lesser     <= 1'b0;
      equal      <= 1'b0;
      greater    <= 1'b0;
      cmp_cycles <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_reg      <= a;
          b_reg      <= b;
          idx        <= IW'(N-1);
          lesser     <= 1'b0;
          equal      <= 1'b0;
          greater    <= 1'b0;
          cmp_cycles <= '0;
        end
        busy: begin
          cmp_cycles <= cmp_cycles + CW'(1);
          // first differing bit decides; a's bit tells direction
          if (diff) begin
            greater <= abit;
            lesser  <= ~abit;
          end else if (last) begin
            equal <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial, MSB-first unsigned magnitude comparator that resolves one bit position per clock and stops at the first differing bit. It returns the same lesser/equal/greater result as the team's single-cycle N-bit comparator, and is used where area matters more than latency. It also serves as a cycle-accurate cross-check partner for that comparator in shared benches. It accepts operands through a start/busy/done handshake and holds its one-hot result until the next accepted start.

## Interface
- N, default 8, operand width in bits (N >= 2)
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled on rising edge; accepted only in IDLE
- a  input  N  unsigned operand A; captured on the accepting edge only
- b  input  N  unsigned operand B; captured on the accepting edge only
- busy  output  1  high while in COMPARE
- done  output  1  one-cycle pulse; result valid from this cycle on
- lesser  output  1  a < b
- equal  output  1  a == b
- greater  output  1  a > b
- cmp_cycles  output  $clog2(N+1)  number of bit positions examined for the last result (1..N)

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE: if start=1 at the edge, capture a and b into shadow registers, set index = N-1, clear lesser/equal/greater and cmp_cycles to 0, go to COMPARE. Otherwise stay in IDLE.
- COMPARE: each cycle examines a_reg[index] versus b_reg[index] and increments cmp_cycles.
  - Bits differ with a bit = 1: greater=1, go to DONE.
  - Bits differ with a bit = 0: lesser=1, go to DONE.
  - Bits equal and index = 0: equal=1, go to DONE.
  - Bits equal and index > 0: index decrements, stay in COMPARE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in COMPARE and in DONE; no queuing. Input changes on a and b after capture have no effect.
- The flags are one-hot after done and all-zero from the accepting edge until done. They hold their value through IDLE until the next accepted start.
- Unsigned arithmetic only; no sign interpretation.

## Timing
- Reset (async assert, any state): state = IDLE; busy, done, lesser, equal, greater = 0; cmp_cycles = 0; shadow registers = 0. Reset mid-COMPARE discards the operation, and no done is produced.
- Reset release: the first accepting edge is the first rising edge with rst_n=1 and start=1.
- Let E0 be the accepting edge. busy goes high after E0.
- If the first difference is at bit i, the decision is registered at edge E0+(N-i). Flags and cmp_cycles = N-i update there, busy falls, and done is high for the cycle E0+(N-i) to E0+(N-i)+1.
- Equal operands: the decision is at E0+N with cmp_cycles = N.
- Latency bounds: minimum 1 cycle (MSB differs), maximum N cycles.
- Back-to-back throughput: the earliest next accepting edge is E0+(N-i)+2, i.e. the first edge in IDLE.

## Test plan
- N=8. Start with a=24, b=56 -> done at E0+3; lesser=1, equal=0, greater=0; cmp_cycles=3.
- Run the sequence (50,24), (52,54), (24,24), (80,51), (50,51) with separate starts, each waiting for done:
  - (50,24) -> greater, 3 cycles
  - (52,54) -> lesser, 7 cycles
  - (24,24) -> equal, 8 cycles
  - (80,51) -> greater, 2 cycles
  - (50,51) -> lesser, 8 cycles
- Boundaries:
  - a=255, b=0 -> greater at E0+1, cmp_cycles=1
  - a=0, b=0 -> equal at E0+8
  - a=0, b=1 -> lesser at E0+8
- Start held high throughout while a, b change every cycle during COMPARE -> results match the captured operands only. Restarts occur exactly at the first IDLE edge after each done, with no start taken during COMPARE or DONE.
- rst_n pulsed low mid-COMPARE of (52,54) -> all outputs 0 immediately and no done pulse. A new start of (80,51) after release -> greater, 2 cycles.
- Randomized 1000 operand pairs -> flags match the combinational comparator reference, and cmp_cycles = N minus the index of the highest differing bit (N when a=b).
